// File: rtl/alu_sequencer_pkg.sv
// Shared encodings for the multicycle ALU sequencer: control classes, R-type
// function codes, ALU ops, plus the request decoder.
package alu_sequencer_pkg;

  localparam logic [1:0] ALU_CTRL_MTYPE = 2'b00;
  localparam logic [1:0] ALU_CTRL_BTYPE = 2'b01;
  localparam logic [1:0] ALU_CTRL_RTYPE = 2'b10;
  localparam logic [1:0] ALU_CTRL_JTYPE = 2'b11;

  localparam logic [5:0] FUNC_ADD   = 6'b100000;
  localparam logic [5:0] FUNC_SUB   = 6'b100010;
  localparam logic [5:0] FUNC_AND   = 6'b100100;
  localparam logic [5:0] FUNC_OR    = 6'b100101;
  localparam logic [5:0] FUNC_SLT   = 6'b101010;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_OFF = 3'b011,
    ALU_MUL = 3'b100,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_t;

  typedef struct packed {
    alu_op_t op;
    logic    illegal;
  } dec_t;

  function automatic dec_t decode(input logic [1:0] ctrl, input logic [5:0] func);
    dec_t d;
    d.op      = ALU_OFF;
    d.illegal = 1'b0;
    case (ctrl)
      ALU_CTRL_MTYPE: d.op = ALU_ADD;
      ALU_CTRL_BTYPE: d.op = ALU_SUB;
      ALU_CTRL_RTYPE: begin
        case (func)
          FUNC_ADD:   d.op = ALU_ADD;
          FUNC_SUB:   d.op = ALU_SUB;
          FUNC_AND:   d.op = ALU_AND;
          FUNC_OR:    d.op = ALU_OR;
          FUNC_SLT:   d.op = ALU_SLT;
          FUNC_MULTU: d.op = ALU_MUL;
          default:    d.illegal = 1'b1;
        endcase
      end
      default: d.op = ALU_OFF;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response bundle between the datapath FSM (master) and the ALU
// sequencer (slave).
interface alu_sequencer_if #(parameter int WIDTH = 32);
  logic                           start;
  logic                           ready;
  logic [1:0]                     alu_ctrl;
  logic [5:0]                     func;
  logic [WIDTH-1:0]               a;
  logic [WIDTH-1:0]               b;
  alu_sequencer_pkg::alu_op_t     alu_op;
  logic [WIDTH-1:0]               result;
  logic [WIDTH-1:0]               hi;
  logic                           zero;
  logic                           illegal;
  logic                           done;

  modport master (
    output start, alu_ctrl, func, a, b,
    input  ready, alu_op, result, hi, zero, illegal, done
  );

  modport slave (
    input  start, alu_ctrl, func, a, b,
    output ready, alu_op, result, hi, zero, illegal, done
  );
endinterface

// File: rtl/alu_sequencer_shift_add_mul.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per step.
// `product` is the accumulator including the current step's partial sum.
module shift_add_mul #(parameter int WIDTH = 32) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 step,
  output logic [2*WIDTH-1:0]   product,
  output logic                 last
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] mcand, acc;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  // Exposing acc+partial lets the caller latch the full product on the final step.
  assign product = acc + (mplier[0] ? mcand : '0);
  assign last    = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= CW'(WIDTH);
    end else if (step && cnt != '0) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/alu_sequencer.sv
// Multicycle ALU sequencer: decodes at acceptance, runs single-step ALU ops in
// one cycle and MULTU over WIDTH cycles, then pulses done for one cycle.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(parameter int WIDTH = 32) (
  input logic            clk,
  input logic            rst,
  alu_sequencer_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ALU, S_MUL, S_DONE} state_t;

  state_t             state, state_d;
  dec_t               dec;
  alu_op_t            op_q;
  logic               ill_pend;
  logic [WIDTH-1:0]   a_q, b_q, alu_res;
  logic [WIDTH-1:0]   result_q, hi_q;
  logic               zero_q, illegal_q;
  logic               accept, mul_load, mul_last;
  logic [2*WIDTH-1:0] product;

  assign dec      = decode(bus.alu_ctrl, bus.func);
  assign bus.ready = (state == S_IDLE) && !rst;
  assign accept   = bus.start && bus.ready;
  assign mul_load = accept && (dec.op == ALU_MUL);

  assign bus.done    = (state == S_DONE);
  assign bus.alu_op  = op_q;
  assign bus.result  = result_q;
  assign bus.hi      = hi_q;
  assign bus.zero    = zero_q;
  assign bus.illegal = illegal_q;

  shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .load    (mul_load),
    .a       (bus.a),
    .b       (bus.b),
    .step    (state == S_MUL),
    .product (product),
    .last    (mul_last)
  );

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (accept) state_d = (dec.op == ALU_MUL) ? S_MUL : S_ALU;
      S_ALU:  state_d = S_DONE;
      S_MUL:  if (mul_last) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (op_q)
      ALU_ADD: alu_res = a_q + b_q;
      ALU_SUB: alu_res = a_q - b_q;
      ALU_AND: alu_res = a_q & b_q;
      ALU_OR:  alu_res = a_q | b_q;
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= ALU_OFF;
      ill_pend  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      hi_q      <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        a_q      <= bus.a;
        b_q      <= bus.b;
        op_q     <= dec.op;
        ill_pend <= dec.illegal;
      end
      if (state == S_ALU) begin
        result_q  <= alu_res;
        hi_q      <= '0;
        zero_q    <= (alu_res == '0);
        illegal_q <= ill_pend;
      end
      if (state == S_MUL && mul_last) begin
        result_q  <= product[WIDTH-1:0];
        hi_q      <= product[2*WIDTH-1:WIDTH];
        zero_q    <= (product[WIDTH-1:0] == '0);
        illegal_q <= 1'b0;
      end
    end
  end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Parametrised, multi-cycle successor to the combinational ALU controller for the multicycle datapath. It accepts one operation per start/ready handshake. It decodes `alu_ctrl`/`func` into an `alu_op`, then executes on registered operands: single-step ALU ops take one cycle, and unsigned multiply is an iterative shift-add over WIDTH cycles. It reports completion with a one-cycle `done` pulse, and the datapath FSM stalls on `ready`.

## Interface
- WIDTH, 32: operand/result width, ≥ 2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted on an edge where `start && ready`.
- ready  out  1  `state==IDLE && !rst`.
- alu_ctrl  in  2  MTYPE / BTYPE / RTYPE / JTYPE class (shared header encodings).
- func  in  6  R-type function field.
- a, b  in  WIDTH  operands, sampled at acceptance only.
- alu_op  out  3  registered decoded op of the last accepted request.
- result  out  WIDTH  low result word.
- hi  out  WIDTH  upper product word; 0 for non-multiply ops.
- zero  out  1  `result==0`, registered with `result`.
- illegal  out  1  last op was RTYPE with an unknown func.
- done  out  1  one-cycle completion pulse.

## Operation
- Decode at acceptance:
  - MTYPE→ALU_ADD; BTYPE→ALU_SUB; JTYPE→ALU_OFF.
  - RTYPE: ADD/SUB/AND/OR/SLT map to their ALU ops; FUNC_MULTU→ALU_MUL.
  - Any other RTYPE func→ALU_OFF with `illegal=1`.
- States: IDLE, ALU, MUL, DONE.
- Transitions:
  - IDLE→MUL on an accepted ALU_MUL.
  - IDLE→ALU on any other accepted op.
  - ALU→DONE after one edge.
  - MUL→DONE after WIDTH step edges.
  - DONE→IDLE unconditionally.
- ALU step: writes `result`. `hi=0`.
  - ADD/SUB: modulo 2^WIDTH, no overflow flag.
  - AND, OR: bitwise.
  - SLT: signed compare, result `{0…,a<b}`.
  - OFF: result 0.
- MUL step: unsigned shift-add of captured a, b into a 2·WIDTH accumulator, with a down-counter of $clog2(WIDTH)+1 bits. At the final step `{hi,result}` = full product.
- Outputs hold their values until the next completion overwrites them.
- `start` while not ready is ignored; no queueing, no error.
- Operand changes after acceptance have no effect.

## Timing
- Accept at edge N.
  - ALU op: `done=1` in cycle N+1..N+2.
  - MUL: `done=1` in cycle N+WIDTH..N+WIDTH+1.
- `result`, `hi`, `zero`, `illegal` are valid from the same edge that raises `done`.
- `ready` goes low after edge N. It returns high after the edge that ends DONE, so back-to-back ops have one idle-visible cycle between them.
- `done` is a combinational decode of the DONE state, glitch-free and exactly 1 cycle wide.
- Reset: on any edge with `rst=1`:
  - state IDLE; counter 0.
  - `result=0`, `hi=0`, `zero=1`, `illegal=0`, `alu_op=ALU_OFF`.
  - `done=0`; `ready=0` while `rst` is high.
- Reset mid-ALU or mid-MUL aborts the op: no `done` is produced, and the partial product is discarded.
- `start` with `rst` high is ignored.

## Structure
- Shared header (`constant_values.h`) holds the existing ALU_CTRL_*, FUNC_* and ALU_* codes, plus these new entries:
  - FUNC_MULTU = 6'b011001.
  - ALU_MUL = 3'b100.
- State encoding is local `localparam`s.
- One sub-module, `shift_add_mul`. Parameter WIDTH. Ports: clk, rst, load, a, b, step, product, last. It is instantiated once.
- Decode and the single-step ALU live in the top.

## Test plan
- Reset: hold `rst` 2 cycles with `start=1` → `ready=0`, `done=0`, `result=0`, `hi=0`, `zero=1`, `alu_op=ALU_OFF`. After release, `ready=1` and nothing has been accepted.
- RTYPE SUB, a=5, b=7 (WIDTH=32) → `done` one cycle after accept, `result=0xFFFFFFFE`, `zero=0`, `alu_op=ALU_SUB`. Then BTYPE a=b=0x1234 → `result=0`, `zero=1`.
- RTYPE SLT, a=0xFFFFFFFF, b=1 → `result=1`. Then a=1, b=0xFFFFFFFF → `result=0`.
- MULTU, a=0xFFFFFFFF, b=2:
  - `done` exactly 32 cycles after accept, `hi=1`, `result=0xFFFFFFFE`.
  - `start` pulses with other operands during busy are ignored, and `ready=0` throughout.
- RTYPE func=6'h3F, a=9, b=9 → `illegal=1`, `result=0`, `alu_op=ALU_OFF`, `done` pulses. JTYPE → `illegal=0`, `result=0`.
- Assert `rst` after 10 MUL steps → no `done`, outputs return to reset values. Then MTYPE a=3, b=4 → `result=7`, `hi=0`, correct latency.
